// File: rtl/fast_to_slow_pkg.sv
// Shared defaults for the fast-producer / slow-consumer sample FIFO.
package fast_to_slow_pkg;
  localparam int DEFAULT_DATA_W = 12;
  localparam int DEFAULT_DEPTH  = 4;
  localparam int DROP_CNT_W     = 16;
endpackage

// File: rtl/fast_to_slow_fifo_mem.sv
// DEPTH x DATA_W sample register file: one write port, one asynchronous read port, no reset.
module fast_to_slow_mem
  import fast_to_slow_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [$clog2(DEPTH)-1:0]    waddr,
  input  logic signed [DATA_W-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0]    raddr,
  output logic signed [DATA_W-1:0]    rdata
);

  logic signed [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fast_to_slow_fifo.sv
// Sample FIFO from a fast producer to a consumer sampling on slow_tick.
// Define FAST_TO_SLOW_FIFO_STATS_EN to add the saturating drop_cnt port.
module fast_to_slow_fifo
  import fast_to_slow_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int DROP_OLDEST = 0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         slow_tick,
  input  logic signed [DATA_W-1:0]     in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [DATA_W-1:0]     out_data,
  output logic                         out_valid,
  output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef FAST_TO_SLOW_FIFO_STATS_EN
  ,
  output logic [DROP_CNT_W-1:0]        drop_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [LVL_W-1:0]          level_q;
  logic [LVL_W-1:0]          level_nxt;
  logic signed [DATA_W-1:0]  rd_data;
  logic signed [DATA_W-1:0]  out_data_p1;
  logic                      vld_p1;
  logic                      full;
  logic                      push;
  logic                      pop;
  logic                      drop;

  // Handshake terms come from registered state only, so in_ready has no input path.
  assign full     = (level_q == DEPTH_L);
  assign in_ready = (DROP_OLDEST != 0) ? 1'b1 : !full;
  assign push     = in_valid && in_ready;
  assign pop      = slow_tick && (level_q != '0);
  assign drop     = push && full && !pop;

  always_comb begin
    level_nxt = level_q;
    case ({push, pop})
      2'b10:   if (!full) level_nxt = level_q + LVL_W'(1);
      2'b01:   level_nxt = level_q - LVL_W'(1);
      default: level_nxt = level_q;
    endcase
  end

  fast_to_slow_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push && reset_n),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Stage p1: head entry captured on pop; a drop advances rd_ptr past the overwritten slot.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      out_data_p1 <= '0;
      vld_p1      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop || drop) rd_ptr <= rd_ptr + PTR_W'(1);
      level_q <= level_nxt;
      vld_p1  <= pop;
      if (pop) out_data_p1 <= rd_data;
    end
  end

  assign out_data  = out_data_p1;
  assign out_valid = vld_p1;
  assign level     = level_q;

`ifdef FAST_TO_SLOW_FIFO_STATS_EN
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == '1) ? v : v + DROP_CNT_W'(1);
  endfunction

  logic [DROP_CNT_W-1:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) drop_cnt_q <= '0;
    else if (drop) drop_cnt_q <= sat_inc(drop_cnt_q);
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fast_to_slow_fifo.sv
// Scoreboard bench: backpressure (u_bp) and drop-oldest (u_do) instances driven side by side.
module tb_fast_to_slow_fifo;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        slow_tick;
  logic [11:0] in_data0, in_data1, out_data0, out_data1;
  logic        in_valid0, in_valid1, in_ready0, in_ready1, out_valid0, out_valid1;
  logic [2:0]  level0, level1;
`ifdef FAST_TO_SLOW_FIFO_STATS_EN
  logic [15:0] drop_cnt0, drop_cnt1;
`endif

  fast_to_slow_fifo #(.DATA_W(12), .DEPTH(4), .DROP_OLDEST(0)) u_bp (
    .clk(clk), .reset_n(reset_n), .slow_tick(slow_tick),
    .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .out_data(out_data0), .out_valid(out_valid0), .level(level0)
`ifdef FAST_TO_SLOW_FIFO_STATS_EN
    , .drop_cnt(drop_cnt0)
`endif
  );

  fast_to_slow_fifo #(.DATA_W(12), .DEPTH(4), .DROP_OLDEST(1)) u_do (
    .clk(clk), .reset_n(reset_n), .slow_tick(slow_tick),
    .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .level(level1)
`ifdef FAST_TO_SLOW_FIFO_STATS_EN
    , .drop_cnt(drop_cnt1)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int cyc_no   = 0;

  logic [11:0] sb0[$];
  logic [11:0] sb1[$];
  logic [11:0] exp_out0, exp_out1;
  logic        exp_vld0, exp_vld1;
  logic [15:0] exp_drop1;
  logic        acc0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc_no, obs, exp);
    end
  endtask

  task automatic cycle(input logic v0, input logic [11:0] d0,
                       input logic v1, input logic [11:0] d1, input logic t);
    logic pop0, pop1;
    in_valid0 = v0; in_data0 = d0;
    in_valid1 = v1; in_data1 = d1;
    slow_tick = t;
    acc0 = 1'b0;
    if (!reset_n) begin
      sb0.delete(); sb1.delete();
      exp_out0 = '0; exp_out1 = '0;
      exp_vld0 = 1'b0; exp_vld1 = 1'b0;
      exp_drop1 = '0;
    end else begin
      acc0 = v0 && (sb0.size() < 4);
      pop0 = t && (sb0.size() > 0);
      exp_vld0 = pop0;
      if (pop0) exp_out0 = sb0.pop_front();
      if (acc0) sb0.push_back(d0);
      pop1 = t && (sb1.size() > 0);
      exp_vld1 = pop1;
      if (pop1) exp_out1 = sb1.pop_front();
      if (v1) begin
        if (sb1.size() == 4) begin
          void'(sb1.pop_front());
          if (exp_drop1 != 16'hFFFF) exp_drop1++;
        end
        sb1.push_back(d1);
      end
    end
    @(posedge clk); #1;
    cyc_no++;
    check("bp.out_valid", 16'(out_valid0), 16'(exp_vld0));
    check("bp.out_data",  16'(out_data0),  16'(exp_out0));
    check("bp.level",     16'(level0),     16'(sb0.size()));
    check("bp.in_ready",  16'(in_ready0),  16'(sb0.size() < 4));
    check("do.out_valid", 16'(out_valid1), 16'(exp_vld1));
    check("do.out_data",  16'(out_data1),  16'(exp_out1));
    check("do.level",     16'(level1),     16'(sb1.size()));
    check("do.in_ready",  16'(in_ready1),  16'(1));
`ifdef FAST_TO_SLOW_FIFO_STATS_EN
    check("bp.drop_cnt",  drop_cnt0, 16'h0000);
    check("do.drop_cnt",  drop_cnt1, exp_drop1);
`endif
  endtask

  initial begin
    logic [11:0] s;
    reset_n = 1'b0;
    // inputs asserted during reset must be ignored
    cycle(1'b1, 12'h7FF, 1'b1, 12'h7FF, 1'b1);
    cycle(1'b1, 12'h7FE, 1'b1, 12'h7FE, 1'b0);
    reset_n = 1'b1;

    // single sample: push, idle, tick, then out_valid only for one cycle
    cycle(1'b1, 12'h123, 1'b1, 12'h123, 1'b0);
    cycle(1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
    cycle(1'b0, 12'h000, 1'b0, 12'h000, 1'b1);
    cycle(1'b0, 12'h000, 1'b0, 12'h000, 1'b0);

    // ticks on an empty buffer
    for (int i = 0; i < 3; i++) cycle(1'b0, 12'h000, 1'b0, 12'h000, 1'b1);

    // empty buffer with push and tick together: only the push takes effect
    cycle(1'b1, 12'h055, 1'b1, 12'h055, 1'b1);
    cycle(1'b0, 12'h000, 1'b0, 12'h000, 1'b1);

    // back-to-back 1..6: backpressure holds sample 5, drop-oldest keeps 3..6
    s = 12'h001;
    for (int i = 1; i <= 6; i++) begin
      cycle(1'b1, s, 1'b1, 12'(i), 1'b0);
      if (acc0) s = s + 12'h001;
    end
    check("bp.held_sample", 16'(s), 16'h0005);
    for (int i = 0; i < 4; i++) cycle(1'b0, 12'h000, 1'b0, 12'h000, 1'b1);
    cycle(1'b0, 12'h000, 1'b0, 12'h000, 1'b0);

    // full buffer with simultaneous push and tick, then drain with consecutive ticks
    for (int i = 0; i < 4; i++) cycle(1'b1, 12'(16 + i), 1'b1, 12'(16 + i), 1'b0);
    cycle(1'b1, 12'h0AA, 1'b1, 12'h0AA, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 12'h000, 1'b0, 12'h000, 1'b1);

    // overwrite with a drop, then mid-operation reset with level 3
    for (int i = 0; i < 5; i++) cycle(1'b1, 12'(32 + i), 1'b1, 12'(32 + i), 1'b0);
    cycle(1'b0, 12'h000, 1'b0, 12'h000, 1'b1);
    cycle(1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
    reset_n = 1'b0;
    cycle(1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
    reset_n = 1'b1;
    cycle(1'b0, 12'h000, 1'b0, 12'h000, 1'b1);
    cycle(1'b0, 12'h000, 1'b0, 12'h000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fast_to_slow_fifo.md
FAST_TO_SLOW_FIFO -- requirements
Module: fast_to_slow_fifo

Interface
REQ-001 Parameter DATA_W, default 12, SHALL set the sample width in bits.
REQ-002 Parameter DEPTH, default 4, SHALL set the buffer depth in entries; it SHALL be a power of two of at least 2.
REQ-003 Parameter DROP_OLDEST, default 0, SHALL select the full-buffer policy: 0 applies backpressure, 1 overwrites the oldest entry.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  SHALL be a synchronous, active-low reset.
REQ-006 slow_tick  in  1  SHALL be a one-cycle strobe marking each slow-consumer sampling instant.
REQ-007 in_data  in  DATA_W  SHALL carry the producer sample.
REQ-008 in_valid  in  1  SHALL mark in_data as valid this cycle.
REQ-009 in_ready  out  1  SHALL indicate that the block accepts a sample this cycle.
REQ-010 out_data  out  DATA_W  SHALL be the registered consumer sample.
REQ-011 out_valid  out  1  SHALL pulse for one cycle when out_data is refreshed.
REQ-012 level  out  $clog2(DEPTH+1)  SHALL report the current occupancy.
REQ-013 drop_cnt  out  16  SHALL count overwritten entries; this port SHALL exist only under REQ-029.

Function
REQ-014 A push SHALL occur on any cycle where in_valid and in_ready are both 1; the sample SHALL be written at wr_ptr, and wr_ptr SHALL increment modulo DEPTH.
REQ-015 in_ready SHALL be !full when DROP_OLDEST=0 and constant 1 when DROP_OLDEST=1; it SHALL depend on registered state only.
REQ-016 A pop SHALL occur on any cycle where slow_tick=1 and level>0; the head entry SHALL be loaded into out_data at that clock edge, rd_ptr SHALL increment modulo DEPTH, and out_valid SHALL be 1 for exactly the following cycle.
REQ-017 On a slow_tick cycle with level=0, out_data SHALL hold its previous value and out_valid SHALL be 0.
REQ-018 There SHALL be no bypass: a sample pushed in cycle N SHALL be poppable no earlier than cycle N+1, so the minimum latency from in_valid to out_valid is 2 cycles.
REQ-019 Push and pop in the same cycle SHALL leave level unchanged; with level=0, only the push SHALL take effect.
REQ-020 When DROP_OLDEST=1 and a push occurs while full with no pop, the oldest entry SHALL be discarded (rd_ptr +1), level SHALL stay at DEPTH, and drop_cnt SHALL increment.
REQ-021 When DROP_OLDEST=1 and a push and pop occur together while full, the pop SHALL return the oldest entry, the push SHALL be stored, and no drop SHALL be counted.
REQ-022 level SHALL never exceed DEPTH, and full SHALL equal (level==DEPTH).
REQ-023 drop_cnt SHALL saturate at 0xFFFF.
REQ-024 slow_tick asserted on consecutive cycles SHALL pop once per cycle while level>0.

Reset
REQ-025 While reset_n=0 at a rising clk edge, wr_ptr, rd_ptr, level, out_data, out_valid and drop_cnt SHALL all clear to 0.
REQ-026 in_ready SHALL be 1 in the first cycle after reset is released.
REQ-027 Reset asserted mid-operation SHALL discard all stored entries; storage contents need not be cleared.
REQ-028 Inputs SHALL be ignored in any cycle where reset_n=0.

Configuration
REQ-029 With FAST_TO_SLOW_FIFO_STATS_EN defined, the drop_cnt port and its counter SHALL be present.
REQ-030 Without FAST_TO_SLOW_FIFO_STATS_EN, drop_cnt and its logic SHALL be absent, and drop behaviour SHALL be otherwise identical.

Structure
REQ-031 Package fast_to_slow_pkg SHALL hold DEFAULT_DATA_W=12, DEFAULT_DEPTH=4 and DROP_CNT_W=16.
REQ-032 Storage SHALL be a sub-module fast_to_slow_mem: a DEPTH x DATA_W register file with one write port and one asynchronous read port, no reset.
REQ-033 Pointer, level and output logic SHALL reside in fast_to_slow_fifo.

Verification
REQ-034 Reset, then push 0x123 in cycle 1, then slow_tick in cycle 3 -> out_data=0x123 and out_valid=1 in cycle 4 only; level returns to 0.
REQ-035 DROP_OLDEST=0, DEPTH=4: push 0x001..0x005 back-to-back -> in_ready=0 after the 4th push, the 5th sample is held by the producer, and level=4.
REQ-036 DROP_OLDEST=1, DEPTH=4: push 0x001..0x006 with no tick, then 4 ticks -> outputs are 0x003, 0x004, 0x005, 0x006 and drop_cnt=2.
REQ-037 Level=0, slow_tick for 3 cycles -> out_valid stays 0 and out_data is unchanged.
REQ-038 Level=3, reset_n=0 for one cycle -> level=0, out_valid=0, drop_cnt=0, and a following tick yields no output.
REQ-039 Full buffer, simultaneous push of 0x0AA and tick -> the oldest entry is output, level stays 4, and drop_cnt is unchanged.
